// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: program counter, I-cache read port, IF branch
// decode for the predictor, and the IF/ID pipeline register with miss
// bubbles, load-use hold and mispredict flush (including a flush that lands
// while a miss is outstanding).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_next_i,
  input  logic        flush_i,
  input  logic        hazard_stall_i,
  input  logic        icache_stall_i,
  input  logic [31:0] icache_rdata_i,
  output logic        icache_ren_o,
  output logic [31:0] icache_addr_o,
  output logic        branch_IF_o,
  output logic [31:0] PC_add_4_o,
  output logic [31:0] PC_add_imm_o,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        branch_ID_o
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS      = 2'd1,
    ST_MISS_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        fetch_ok_s;
  logic        accept_s;
  logic [31:0] b_imm_s;

  // Sign-extended B-type immediate of the word currently returned by the cache.
  function automatic logic [31:0] b_imm(input logic [31:0] r);
    b_imm = {{19{r[31]}}, r[31], r[7], r[30:25], r[11:8], 1'b0};
  endfunction

  // A returned word is only usable when the cache hit and it is not wrong-path.
  assign fetch_ok_s = !icache_stall_i && (state_q != ST_MISS_DROP);
  assign accept_s   = fetch_ok_s && !hazard_stall_i && !flush_i;
  assign b_imm_s    = b_imm(icache_rdata_i);

  assign icache_ren_o  = !rst_i;
  // Address stays on the stale PC during MISS_DROP so the cache sees a stable request.
  assign icache_addr_o = pc_q;
  assign branch_IF_o   = accept_s && (icache_rdata_i[6:0] == OPC_BRANCH);
  assign PC_add_4_o    = pc_q + 32'd4;
  assign PC_add_imm_o  = pc_q + b_imm_s;
  assign id_valid_o    = id_valid_q;
  assign id_instr_o    = id_instr_q;
  assign id_pc_o       = id_pc_q;
  assign branch_ID_o   = id_valid_q && (id_instr_q[6:0] == OPC_BRANCH);

  // Next-state logic: flush beats load-use hold, which beats miss handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      if (!icache_stall_i) begin
        pc_d    = pc_next_i;
        state_d = ST_RUN;
      end else begin
        // Cache is busy with the wrong-path fetch: remember where to go.
        redirect_d = pc_next_i;
        state_d    = ST_MISS_DROP;
      end
    end else if (hazard_stall_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN, ST_MISS: begin
          if (icache_stall_i) begin
            state_d    = ST_MISS;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end else begin
            pc_d       = pc_next_i;
            id_instr_d = icache_rdata_i;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
        ST_MISS_DROP: begin
          if (icache_stall_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end else begin
            // Wrong-path word returned: drop it and take the saved redirect.
            pc_d       = redirect_q;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            state_d    = ST_RUN;
          end
        end
        default: begin
          state_d    = ST_RUN;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // State, PC and IF/ID register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 32'h0000_0000;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It holds the program counter, drives the instruction-cache read port, and decodes branch opcodes in IF. It feeds the branch predictor with `branch_IF`, `PC_add_4` and `PC_add_imm`, and takes the predictor's `PC_out` back as the next PC. It also owns the IF/ID pipeline register, including bubble insertion on I-cache misses, load-use hold, and flush on branch mispredict, including a mispredict that lands while a miss is outstanding.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction word presented in ID when `id_valid`=0 (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_next`  in  32  next PC from the branch predictor (`PC_out`).
- `flush`  in  1  mispredict in ID (predictor `correct`==0); IF content is wrong-path.
- `hazard_stall`  in  1  load-use stall from the hazard unit; freezes IF and IF/ID.
- `icache_stall`  in  1  I-cache miss; `icache_rdata` not valid this cycle.
- `icache_rdata`  in  32  instruction word for `icache_addr`.
- `icache_ren`  out  1  I-cache read enable.
- `icache_addr`  out  32  fetch address.
- `branch_IF`  out  1  a branch opcode is being accepted into IF/ID this cycle.
- `PC_add_4`  out  32  `pc_q + 4`.
- `PC_add_imm`  out  32  `pc_q` + sign-extended B-type immediate of `icache_rdata`.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  IF/ID PC.
- `branch_ID`  out  1  `id_valid` and `id_instr[6:0]`==7'b1100011.

## Operation
- States: RUN, MISS, MISS_DROP. Reset puts the block in RUN with `pc_q`=`RESET_PC`, `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=0, and `redirect_q`=0.
- `icache_addr`=`pc_q` in every state. `icache_ren`=0 while `rst`=1, and 1 otherwise.
- `fetch_ok` = `!icache_stall` in RUN or MISS; it is 0 in MISS_DROP.
- Accept = `fetch_ok && !hazard_stall && !flush`.
  - On accept: `pc_q`<=`pc_next`, `id_instr`<=`icache_rdata`, `id_pc`<=`pc_q`, `id_valid`<=1.
- `branch_IF` = accept && `icache_rdata[6:0]`==7'b1100011. It pulses exactly on the cycle the branch enters IF/ID.
- `PC_add_imm` uses B-immediate = {{19{r[31]}}, r[31], r[7], r[30:25], r[11:8], 1'b0}, where r=`icache_rdata`. The add wraps modulo 2^32.
- Flush has priority over `hazard_stall`.
  - Flush with `icache_stall`=0: `pc_q`<=`pc_next`, `id_valid`<=0, `id_instr`<=`NOP_INSTR`. State stays or returns to RUN.
  - Flush with `icache_stall`=1: `redirect_q`<=`pc_next`, `pc_q` is held, `id_valid`<=0, and the state goes to MISS_DROP.
- `hazard_stall`=1 without flush: `pc_q`, `id_*` and the state are held, regardless of `icache_stall`.
- RUN with `icache_stall`=1 (no flush, no hazard): go to MISS. `pc_q` is held and `id_valid`<=0 (a bubble into ID).
- MISS:
  - While `icache_stall`=1: hold and keep inserting bubbles.
  - When `icache_stall` falls: normal accept, then return to RUN.
  - A flush in MISS follows the same two rules as a flush in RUN.
- MISS_DROP:
  - `icache_addr` stays at the stale `pc_q` until `icache_stall`=0, because the cache requires a stable address until it completes.
  - The cycle `icache_stall`=0: the returned data is discarded, `pc_q`<=`redirect_q`, `id_valid`<=0, and the state goes to RUN.
  - A further flush in MISS_DROP overwrites `redirect_q`.
- When `rst`=1 in any state, the reset values are restored on the next edge and any pending redirect is abandoned.

## Timing
- PC to IF/ID latency is 1 cycle: an instruction fetched at edge N appears on `id_*` after edge N+1.
- On a hit, a new PC is accepted every cycle.
- Flush in RUN: the redirected PC is on `icache_addr` the cycle after `flush`, giving a 1-bubble penalty.
- Flush during a miss: the penalty is the remaining miss cycles plus 1.
- `branch_IF`, `PC_add_4`, `PC_add_imm` and `icache_ren` are combinational from registered state and `icache_rdata`/stall inputs.
- `branch_ID` is combinational from IF/ID only.
- No combinational path from `pc_next` to any output.

## Test plan
- Reset then run: hold `rst`=1 for 2 cycles. Expect `icache_addr`=0, `id_valid`=0, `id_instr`=0x00000013. Then release, feed 0x00000013 with no stalls and `pc_next`=`PC_add_4`. Expect `icache_addr` to go 0, 4, 8 and `id_pc` to go 0, 4 one cycle later.
- Branch in IF: at `pc_q`=0x10, `icache_rdata`=0x00000463 (beq +8). Expect `branch_IF`=1, `PC_add_4`=0x14, `PC_add_imm`=0x18. Next cycle expect `branch_ID`=1 and `id_pc`=0x10.
- Mispredict flush: with `flush`=1 and `pc_next`=0x18 at `pc_q`=0x14, expect `icache_addr`=0x18 next cycle and `id_valid`=0 with `id_instr`=0x00000013.
- Miss: `icache_stall`=1 for 3 cycles at 0x20. Expect `icache_addr` held at 0x20, `id_valid`=0 for 3 cycles, `branch_IF`=0. On release expect `id_pc`=0x20 and `icache_addr`=0x24.
- Flush during miss: miss at 0x20, and on its first cycle `flush`=1 with `pc_next`=0x40. Expect `icache_addr` to stay 0x20 while stalled and the returned word to be dropped (`id_valid`=0). The cycle after release expect `icache_addr`=0x40.
- Load-use hold: `hazard_stall`=1 for 2 cycles at `pc_q`=0x30 with a branch word present. Expect `pc_q` and `id_*` unchanged and `branch_IF`=0. After release expect `branch_IF`=1 exactly once.
